multicycle_controller: RTL and testbench

- Next-generation MIPS control unit for the multicycle datapath.
- Replaces the single-cycle decoder with a Moore FSM that sequences each instruction over 3–5 cycles (more with memory wait states).
- Drives the shared-memory, IR, ALU-mux and PC-enable controls.
- Adds bne, andi, ori and slti (zero-extend via immext), a parametrised memory handshake and an illegal-opcode flag.

---
 rtl/multicycle_controller.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM sequencing MIPS instructions over the multicycle datapath.
// Define MCC_INSTRET_EN to add the 32-bit retired-instruction counter output instret.
module multicycle_controller #(
    parameter int unsigned ALUC_W   = 3,
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              iord,
    output logic              memwrite,
    output logic              irwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic              pcen,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              immext,
    output logic              illegal,
`ifdef MCC_INSTRET_EN
    output logic [31:0]       instret,
`endif
    output logic              retire
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [3:0] WaitMax = 4'(MEM_WAIT);

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StExecute, StAluWb, StBranch, StIExec, StIWb, StJump
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_done;
    logic [2:0] alu, funct_alu, imm_alu;
    logic       funct_ok, imm_zext;

    assign mem_done   = (cnt_q == WaitMax) && mem_ready;
    assign alucontrol = ALUC_W'(alu);

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
        imm_alu  = 3'b010;
        imm_zext = 1'b0;
        case (op)
            OpAndi:  begin imm_alu = 3'b000; imm_zext = 1'b1; end
            OpOri:   begin imm_alu = 3'b001; imm_zext = 1'b1; end
            OpSlti:  imm_alu = 3'b111;
            default: imm_alu = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:   if (mem_done) state_d = StDecode;
            StDecode: begin
                case (op)
                    OpRtype:                        state_d = StExecute;
                    OpLw, OpSw:                     state_d = StMemAdr;
                    OpBeq, OpBne:                   state_d = StBranch;
                    OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
                    OpJ:                            state_d = StJump;
                    default:                        state_d = StFetch;
                endcase
            end
            StMemAdr:  state_d = (op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (mem_done) state_d = StMemWb;
            StMemWr:   if (mem_done) state_d = StFetch;
            StExecute: state_d = funct_ok ? StAluWb : StFetch;
            StIExec:   state_d = StIWb;
            default:   state_d = StFetch;
        endcase
        // Any state change restarts the wait count; otherwise count up and saturate.
        if (state_d != state_q) cnt_d = 4'd0;
        else if (cnt_q == WaitMax) cnt_d = cnt_q;
        else cnt_d = cnt_q + 4'd1;
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcen     = 1'b0;
        alu      = 3'b010;
        immext   = 1'b0;
        illegal  = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            StFetch: begin
                alusrcb = 2'b01;
                irwrite = mem_done;
                pcen    = mem_done;
            end
            StDecode: begin
                alusrcb = 2'b11;
                if (state_d == StFetch) begin
                    illegal = 1'b1;
                    retire  = 1'b1;
                end
            end
            StMemAdr: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                retire   = mem_done;
            end
            StExecute: begin
                alusrca = 1'b1;
                alu     = funct_alu;
                illegal = ~funct_ok;
                retire  = ~funct_ok;
            end
            StAluWb: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            StBranch: begin
                alusrca = 1'b1;
                alu     = 3'b110;
                pcsrc   = 2'b01;
                pcen    = ((op == OpBeq) & zero) | ((op == OpBne) & ~zero);
                retire  = 1'b1;
            end
            StIExec: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                alu     = imm_alu;
                immext  = imm_zext;
            end
            StIWb: begin
                regwrite = 1'b1;
                retire   = 1'b1;
                alu      = imm_alu;
                immext   = imm_zext;
            end
            StJump: begin
                pcsrc  = 2'b10;
                pcen   = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
        // Write strobes must stay quiet for the whole time reset is held.
        if (!reset) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            pcen     = 1'b0;
        end
    end

`ifdef MCC_INSTRET_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) instret <= 32'd0;
        else if (retire && !illegal) instret <= instret + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: MEM_WAIT=0 instance for the instruction mix
// and reset abort, MEM_WAIT=2 instance for memory wait-state handling.
module tb_multicycle_controller;

    typedef logic [17:0] ovec_t;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpOri  = 6'b001101;
    localparam logic [5:0] OpSlti = 6'b001010;
    localparam logic [5:0] OpJ    = 6'b000010;
    localparam ovec_t      AllBits = '1;
    localparam ovec_t      NoAlu   = ~18'h00038;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen;
    logic       immext, illegal, retire;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;

    logic       reset2, zero2, mem_ready2;
    logic [5:0] op2, funct2;
    logic       iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2, pcen2;
    logic       immext2, illegal2, retire2;
    logic [1:0] alusrcb2, pcsrc2;
    logic [2:0] alucontrol2;
`ifdef MCC_INSTRET_EN
    logic [31:0] instret, instret2;
`endif

    multicycle_controller #(.ALUC_W(3), .MEM_WAIT(0)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .immext(immext),
        .illegal(illegal),
`ifdef MCC_INSTRET_EN
        .instret(instret),
`endif
        .retire(retire)
    );

    multicycle_controller #(.ALUC_W(3), .MEM_WAIT(2)) dut2 (
        .clk(clk), .reset(reset2), .op(op2), .funct(funct2), .zero(zero2),
        .mem_ready(mem_ready2), .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2),
        .regdst(regdst2), .memtoreg(memtoreg2), .regwrite(regwrite2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .pcsrc(pcsrc2), .pcen(pcen2), .alucontrol(alucontrol2),
        .immext(immext2), .illegal(illegal2),
`ifdef MCC_INSTRET_EN
        .instret(instret2),
`endif
        .retire(retire2)
    );

    ovec_t ovec0, ovec2;
    assign ovec0 = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
                    pcen, alucontrol, immext, illegal, retire};
    assign ovec2 = {iord2, memwrite2, irwrite2, regdst2, memtoreg2, regwrite2, alusrca2, alusrcb2,
                    pcsrc2, pcen2, alucontrol2, immext2, illegal2, retire2};

    ovec_t exp_q[$];
    ovec_t mask_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  sel      = 1'b0;

    function automatic ovec_t ov(logic io, logic mw, logic irw, logic rd, logic mtr, logic rw,
                                 logic asa, logic [1:0] asb, logic [1:0] ps, logic pce,
                                 logic [2:0] alu, logic imm, logic ill, logic ret);
        return {io, mw, irw, rd, mtr, rw, asa, asb, ps, pce, alu, imm, ill, ret};
    endfunction

    function automatic ovec_t e_fetch(logic done);
        return ov(0, 0, done, 0, 0, 0, 0, 2'b01, 2'b00, done, 3'b010, 0, 0, 0);
    endfunction
    function automatic ovec_t e_decode(logic ill);
        return ov(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 3'b010, 0, ill, ill);
    endfunction
    function automatic ovec_t e_memadr();
        return ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 3'b010, 0, 0, 0);
    endfunction
    function automatic ovec_t e_memrd();
        return ov(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0, 0);
    endfunction
    function automatic ovec_t e_memwb();
        return ov(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0, 1);
    endfunction
    function automatic ovec_t e_memwr(logic done);
        return ov(1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0, done);
    endfunction
    function automatic ovec_t e_exec(logic [2:0] alu, logic ill);
        return ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, alu, 0, ill, ill);
    endfunction
    function automatic ovec_t e_aluwb();
        return ov(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 3'b010, 0, 0, 1);
    endfunction
    function automatic ovec_t e_branch(logic pce);
        return ov(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, pce, 3'b110, 0, 0, 1);
    endfunction
    function automatic ovec_t e_iexec(logic [2:0] alu, logic imm);
        return ov(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, alu, imm, 0, 0);
    endfunction
    function automatic ovec_t e_iwb(logic [2:0] alu, logic imm);
        return ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0, alu, imm, 0, 1);
    endfunction
    function automatic ovec_t e_jump();
        return ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 1, 3'b010, 0, 0, 1);
    endfunction

    function automatic void push(string t, ovec_t v, ovec_t m);
        exp_q.push_back(v);
        mask_q.push_back(m);
        tag_q.push_back(t);
    endfunction

    task automatic check_head(input ovec_t obs);
        ovec_t e, m;
        string t;
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h, required a queued entry", obs);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            t = tag_q.pop_front();
            assert ((obs & m) === (e & m)) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", t, obs & m, e & m);
            end
        end
    endtask

    task automatic check32(input string t, input logic [31:0] obs, input logic [31:0] e);
        n_checks++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", t, obs, e);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, sample, then move to the next fall.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        if (sel) begin
            op2 = o; funct2 = f; zero2 = z; mem_ready2 = r;
        end else begin
            op = o; funct = f; zero = z; mem_ready = r;
        end
        #1;
        check_head(sel ? ovec2 : ovec0);
        @(negedge clk);
    endtask

    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z);
        while (exp_q.size() > 0) step(o, f, z, 1'b1);
    endtask

    task automatic head(input string t);
        push({t, "_fetch"}, e_fetch(1), AllBits);
        push({t, "_decode"}, e_decode(0), AllBits);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = 6'h3f; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        reset2 = 1'b0; op2 = 6'h00; funct2 = 6'h00; zero2 = 1'b0; mem_ready2 = 1'b0;

        // Held in reset with memory ready: FETCH outputs, strobes suppressed.
        @(negedge clk);
        push("reset_hold", e_fetch(0), AllBits);
        step(6'h3f, 6'h00, 1'b0, 1'b1);
`ifdef MCC_INSTRET_EN
        check32("instret_reset", instret, 32'd0);
`endif
        reset = 1'b1;

        head("lw");
        push("lw_memadr", e_memadr(), AllBits);
        push("lw_memrd", e_memrd(), AllBits);
        push("lw_memwb", e_memwb(), AllBits);
        run(OpLw, 6'h00, 1'b0);

        head("sub");
        push("sub_execute", e_exec(3'b110, 0), AllBits);
        push("sub_aluwb", e_aluwb(), AllBits);
        run(6'b000000, 6'b100010, 1'b0);

        head("badfunct");
        push("badfunct_execute", e_exec(3'b010, 1), NoAlu);
        run(6'b000000, 6'b111111, 1'b0);

        head("beq_z1");
        push("beq_z1_branch", e_branch(1), AllBits);
        run(OpBeq, 6'h00, 1'b1);
        head("beq_z0");
        push("beq_z0_branch", e_branch(0), AllBits);
        run(OpBeq, 6'h00, 1'b0);
        head("bne_z1");
        push("bne_z1_branch", e_branch(0), AllBits);
        run(OpBne, 6'h00, 1'b1);
        head("bne_z0");
        push("bne_z0_branch", e_branch(1), AllBits);
        run(OpBne, 6'h00, 1'b0);

        head("ori");
        push("ori_iexec", e_iexec(3'b001, 1), AllBits);
        push("ori_iwb", e_iwb(3'b001, 1), AllBits);
        run(OpOri, 6'h00, 1'b0);
        head("addi");
        push("addi_iexec", e_iexec(3'b010, 0), AllBits);
        push("addi_iwb", e_iwb(3'b010, 0), AllBits);
        run(OpAddi, 6'h00, 1'b0);
        head("andi");
        push("andi_iexec", e_iexec(3'b000, 1), AllBits);
        push("andi_iwb", e_iwb(3'b000, 1), AllBits);
        run(OpAndi, 6'h00, 1'b0);
        head("slti");
        push("slti_iexec", e_iexec(3'b111, 0), AllBits);
        push("slti_iwb", e_iwb(3'b111, 0), AllBits);
        run(OpSlti, 6'h00, 1'b0);

        head("j");
        push("j_jump", e_jump(), AllBits);
        run(OpJ, 6'h00, 1'b0);

        push("badop_fetch", e_fetch(1), AllBits);
        push("badop_decode", e_decode(1), AllBits);
        run(6'b111111, 6'h00, 1'b0);

        head("sw");
        push("sw_memadr", e_memadr(), AllBits);
        push("sw_memwr", e_memwr(1), AllBits);
        run(OpSw, 6'h00, 1'b0);
`ifdef MCC_INSTRET_EN
        // lw, sub, four branches, four immediates, j, sw retire; the two illegals do not.
        check32("instret_count", instret, 32'd12);
`endif

        // Abort an lw in MEMADR with an asynchronous reset.
        head("abort");
        run(OpLw, 6'h00, 1'b0);
        push("abort_memadr", e_memadr(), AllBits);
        #1;
        check_head(ovec0);
        #1;
        reset = 1'b0;
        push("abort_async_fetch", e_fetch(0), AllBits);
        #1;
        check_head(ovec0);
        @(negedge clk);
        push("abort_held_fetch", e_fetch(0), AllBits);
        #1;
        check_head(ovec0);
`ifdef MCC_INSTRET_EN
        check32("instret_abort", instret, 32'd0);
`endif
        reset = 1'b1;
        head("recover");
        push("recover_jump", e_jump(), AllBits);
        run(OpJ, 6'h00, 1'b0);

        // MEM_WAIT=2 instance: sw with memory not ready for the first MEMWR cycles.
        sel = 1'b1;
        reset2 = 1'b1;
        push("w_fetch_c0", e_fetch(0), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b1);
        push("w_fetch_c1", e_fetch(0), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b1);
        push("w_fetch_c2", e_fetch(1), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b1);
        push("w_decode", e_decode(0), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b0);
        push("w_memadr", e_memadr(), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            push("w_memwr_hold", e_memwr(0), AllBits);
            step(OpSw, 6'h00, 1'b0, (i == 1) ? 1'b1 : 1'b0);
        end
        push("w_memwr_done", e_memwr(1), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b1);
        // Counter must restart on re-entering FETCH, so ready alone cannot complete it.
        push("w_refetch_c0", e_fetch(0), AllBits);
        step(OpSw, 6'h00, 1'b0, 1'b1);
`ifdef MCC_INSTRET_EN
        check32("instret2_sw", instret2, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
